// File: rtl/layer0_ctrl_pkg.sv
// Shared definitions for the layer-0 convolution controller.
// Holds the datapath word width, kernel size, filter count, frame
// geometry, pipeline latency and the controller state encoding.
// No ports; imported by every file of this block.
package layer0_ctrl_pkg;

  localparam int BIT_INL0     = 8;
  localparam int CONV2D_KSIZE = 3;
  localparam int FILTER_L0    = 8;
  localparam int IMG_W_L0     = 28;
  localparam int IMG_H_L0     = 28;
  localparam int PIPE_LAT_L0  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

endpackage

// File: rtl/layer0_ctrl_valid_delay.sv
// valid_delay: DEPTH-stage, WIDTH-bit shift register with synchronous
// clear. It carries the output-valid tag together with its row/col so that
// both reach the datapath output in the same cycle.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   clear         - synchronous flush of every stage
//   sample        - word entering stage 0
//   delayed       - word leaving the last stage
module valid_delay
  import layer0_ctrl_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_L0,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Flushing on clear drops anything still in flight, so an aborted frame
  // can never emit a stale output position.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= sample;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/layer0_ctrl.sv
// layer0_ctrl: sequencer for the first conv layer (conv2d -> scale -> relu).
// Broadcast-loads KSIZE*KSIZE weight words, streams one IMG_W x IMG_H frame
// into the datapath and tags each datapath result with out_valid plus its
// output row/col, aligned to the fixed datapath latency.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   start, abort          - begin a frame (IDLE only) / early termination
//   w_in, w_valid/w_ready - weight word handshake
//   in_x, in_valid/in_ready - pixel handshake
//   load, w, x            - datapath drive (weight load strobe, weight, pixel)
//   out_valid, out_row, out_col - valid output position of the datapath
//   busy, done, aborted   - status: active, completion pulse, abort pulse
module layer0_ctrl
  import layer0_ctrl_pkg::*;
#(
  parameter int IMG_W    = IMG_W_L0,
  parameter int IMG_H    = IMG_H_L0,
  parameter int KSIZE    = CONV2D_KSIZE,
  parameter int PIPE_LAT = PIPE_LAT_L0,
  parameter int BIT_IN   = BIT_INL0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [BIT_IN-1:0]        w_in,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [BIT_IN-1:0]        in_x,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     load,
  output logic [BIT_IN-1:0]        w,
  output logic [BIT_IN-1:0]        x,
  output logic                     out_valid,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int TAPS = KSIZE * KSIZE;
  localparam int WCW  = $clog2(TAPS + 1);
  localparam int DCW  = $clog2(PIPE_LAT + 1);
  localparam int PW   = 1 + RW + CW;

  localparam logic [RW-1:0]  ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0]  COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_FIRST  = RW'(KSIZE - 1);
  localparam logic [CW-1:0]  COL_FIRST  = CW'(KSIZE - 1);
  localparam logic [WCW-1:0] W_LAST     = WCW'(TAPS - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE_LAT - 1);

  ctrl_state_t    state;
  logic [WCW-1:0] w_count;
  logic [DCW-1:0] drain_count;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;

  logic           tag_valid;
  logic [RW-1:0]  tag_row;
  logic [CW-1:0]  tag_col;

  logic           w_xfer;
  logic           in_xfer;
  logic           tag;
  logic           take_abort;
  logic [PW-1:0]  pipe_head;
  logic [PW-1:0]  pipe_tail;

  assign w_xfer     = w_valid && w_ready;
  assign in_xfer    = in_valid && in_ready;
  assign take_abort = abort && (state != ST_IDLE);

  // A position is a valid conv output only once a full KSIZE x KSIZE
  // window is available, judged on the position before it advances.
  assign tag = in_xfer && (col >= COL_FIRST) && (row >= ROW_FIRST);

  // The tag is registered alongside x so it refers to the cycle in which
  // the pixel is presented to the datapath; the delay line then adds the
  // datapath latency on top of that.
  assign pipe_head = {tag_valid, tag_row, tag_col};

  valid_delay #(
    .DEPTH (PIPE_LAT),
    .WIDTH (PW)
  ) u_valid_delay (
    .clock   (clock),
    .reset   (reset),
    .clear   (take_abort),
    .sample  (pipe_head),
    .delayed (pipe_tail)
  );

  assign out_valid = pipe_tail[PW-1];
  assign out_row   = pipe_tail[CW +: RW];
  assign out_col   = pipe_tail[CW-1:0];

  // Controller FSM. Every datapath-facing and status output is a register
  // updated here, so the datapath sees clean, edge-aligned controls. Abort
  // outranks every state but IDLE, where it is ignored so that a start in
  // the same cycle still wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      w_count     <= '0;
      drain_count <= '0;
      row         <= '0;
      col         <= '0;
      tag_valid   <= 1'b0;
      tag_row     <= '0;
      tag_col     <= '0;
      load        <= 1'b0;
      w           <= '0;
      x           <= '0;
      w_ready     <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else if (take_abort) begin
      state       <= ST_IDLE;
      w_count     <= '0;
      drain_count <= '0;
      row         <= '0;
      col         <= '0;
      tag_valid   <= 1'b0;
      tag_row     <= '0;
      tag_col     <= '0;
      load        <= 1'b0;
      x           <= '0;
      w_ready     <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b1;
    end else begin
      load      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      x         <= '0;
      tag_valid <= 1'b0;
      tag_row   <= '0;
      tag_col   <= '0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD_W;
            w_count <= '0;
            w_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end

        ST_LOAD_W: begin
          if (w_xfer) begin
            w    <= w_in;
            load <= 1'b1;
            if (w_count == W_LAST) begin
              state    <= ST_STREAM;
              w_count  <= '0;
              w_ready  <= 1'b0;
              in_ready <= 1'b1;
              row      <= '0;
              col      <= '0;
            end else begin
              w_count <= w_count + WCW'(1);
            end
          end
        end

        ST_STREAM: begin
          if (in_xfer) begin
            x         <= in_x;
            tag_valid <= tag;
            if (tag) begin
              tag_row <= row - ROW_FIRST;
              tag_col <= col - COL_FIRST;
            end
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row         <= '0;
                state       <= ST_DRAIN;
                in_ready    <= 1'b0;
                drain_count <= '0;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end

        // Wait out the datapath latency so the last tagged position has
        // left the delay line before completion is reported.
        ST_DRAIN: begin
          if (drain_count == DRAIN_LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_count <= drain_count + DCW'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/layer0_ctrl.md
Name: layer0_ctrl

Overview:
- Sequencer for the first conv layer datapath (conv2d -> scale -> relu, one lane per filter).
- Three jobs: broadcast-loads the filter weight words, streams one input-feature-map frame with a valid/ready handshake, and tags datapath outputs with a valid aligned to the fixed pipeline latency.
- Counts output positions, supports early-termination abort, and reports frame completion.

Parameters:
- IMG_W, 28, input frame width in pixels
- IMG_H, 28, input frame height in pixels
- KSIZE, 3, conv kernel edge (taps per filter = KSIZE*KSIZE)
- PIPE_LAT, 4, cycles from x presented to z valid (conv + scale + relu)
- BIT_IN, `BIT_INL0, width of x and w words

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; accepted only in IDLE
- abort  in  1  early-termination request; highest priority after reset
- w_in  in  BIT_IN  weight word from weight memory
- w_valid  in  1  w_in valid
- w_ready  out  1  controller accepts w_in
- in_x  in  BIT_IN  input pixel
- in_valid  in  1  in_x valid
- in_ready  out  1  controller accepts in_x
- load  out  1  drives datapath load; asserted when a weight word is accepted
- w  out  BIT_IN  weight to datapath (registered w_in)
- x  out  BIT_IN  pixel to datapath (registered in_x, zero when no transfer)
- out_valid  out  1  z is a valid output position this cycle
- out_row  out  clog2(IMG_H)  output row index of current z
- out_col  out  clog2(IMG_W)  output col index of current z
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame completion
- aborted  out  1  one-cycle pulse when abort is taken

Behaviour:
- Reset values: state IDLE. All of load, w, x, w_ready, in_ready, out_valid, out_row, out_col, done, aborted, busy are 0. Counters and the valid shift register are 0.
- IDLE: start=1 -> LOAD_W. Weight counter is cleared.
- LOAD_W:
  - w_ready=1.
  - Each w_valid&w_ready transfer registers w_in to w and asserts load for that one cycle.
  - After KSIZE*KSIZE transfers -> STREAM.
  - w_valid low: wait; no load.
- STREAM:
  - in_ready=1.
  - A transfer (in_valid&in_ready) registers in_x to x and advances col (wraps at IMG_W-1 to 0, then increments row).
  - No transfer: x=0; counters hold; the tag bit for that cycle is 0.
  - Tag bit = transfer AND col>=KSIZE-1 AND row>=KSIZE-1, using the pre-increment position.
  - The tag enters a PIPE_LAT-deep shift register whose tail is out_valid. out_row/out_col = position-(KSIZE-1), delayed the same amount.
  - On the last pixel (row=IMG_H-1, col=IMG_W-1): -> DRAIN.
- DRAIN: in_ready=0. Counts PIPE_LAT cycles, then -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Output count per frame is exactly (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1). Latency from the accepting edge of the last pixel to the last out_valid is PIPE_LAT cycles.
- abort in any non-IDLE state:
  - Next cycle state=IDLE, aborted=1 for one cycle.
  - Shift register, counters, load and ready signals are cleared.
  - No out_valid after the abort edge. done is not asserted.
- abort in IDLE: ignored.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: start wins (abort ignored in IDLE).
- reset mid-frame: same as the reset values; the datapath weights are cleared by its own reset.
- Back-to-back frames: start may be asserted in the DONE cycle. It is accepted only once in IDLE, so the minimum gap is 1 cycle.

Decomposition:
- Shared definitions header: BIT_INL0, CONV2D_KSIZE, FILTER_L0, and new IMG_W_L0, IMG_H_L0, PIPE_LAT_L0.
- One sub-module: valid_delay. A parameterised DEPTH x WIDTH shift register with synchronous clear, used for the tag plus row/col.

Test Plan:
- Weight load: IMG 5x5, KSIZE 3. Present 9 weights 1..9 with w_valid gaps of 1 cycle -> exactly 9 load pulses, w matches each word, then STREAM with in_ready=1.
- Full frame: 25 pixels back-to-back -> exactly 9 out_valid. First out_valid is 4 cycles after the pixel at (2,2) with out_row=0, out_col=0. Last is (2,2). done is 4 cycles after the last pixel. busy falls next cycle.
- Stalled input: in_valid low every 3rd cycle -> same 9 outputs and coordinates, x=0 in stall cycles, done delayed by the stall count.
- Abort: assert abort on the 12th pixel -> aborted pulse next cycle, state IDLE, zero further out_valid, no done.
- Reset mid-STREAM at pixel 7 -> all outputs 0 next cycle. A new start then reloads 9 weights.
- Ignored controls: start during STREAM and abort in IDLE -> no state change. start in the DONE cycle -> frame 2 begins one cycle after IDLE.
